// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared types and constants for the AES-128 key schedule controller and round datapath.
package aes_key_sched_ctrl_pkg;

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned RK_IDX_W   = 4;

  typedef logic [RK_IDX_W-1:0] rk_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } state_e;

  // Round-key read response as seen by the round controller
  typedef struct packed {
    logic [KEY_W-1:0] data;
    logic             hit;
  } rk_rsp_t;

  localparam logic [7:0] RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Out-of-range round counters map to zero rather than indexing past the table
  function automatic logic [7:0] rcon_lookup(input rk_idx_t rc);
    logic [7:0] v;
    v = 8'h00;
    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
      if (rc == rk_idx_t'(i)) v = RCON[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load and round-key read bus between the key scheduler and its neighbours.
interface aes_key_sched_ctrl_if;
  import aes_key_sched_ctrl_pkg::*;

  logic [KEY_W-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic             busy;
  logic             keys_ready;
  logic             done;
  rk_idx_t          rk_idx;
  logic [KEY_W-1:0] rk_data;
  logic             rk_hit;

  modport master (
    output key_in, key_valid, rk_idx,
    input  key_ready, busy, keys_ready, done, rk_data, rk_hit
  );

  modport slave (
    input  key_in, key_valid, rk_idx,
    output key_ready, busy, keys_ready, done, rk_data, rk_hit
  );

endinterface

// File: rtl/aes_key_sched_ctrl_key.sv
// Single AES-128 key-expansion step: derives round key rc+1 from round key rc (combinational).
module aes_key_sched_ctrl_key
  import aes_key_sched_ctrl_pkg::*;
(
  input  rk_idx_t          rc,
  input  logic [KEY_W-1:0] k_in,
  output logic [KEY_W-1:0] k_out
);

  // Forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0   = k_in[127:96];
    w1   = k_in[95:64];
    w2   = k_in[63:32];
    w3   = k_in[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
            sub_byte(rot[15:8]),  sub_byte(rot[7:0])};
    temp = temp ^ {rcon_lookup(rc), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    k_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands a loaded key into 11 round keys and serves indexed reads.
// Optional build macro KEYSCHED_ZEROIZE_EN adds a zeroize input and a resettable key store.
module aes_key_sched_ctrl
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic zeroize,
`endif
  aes_key_sched_ctrl_if.slave bus
);

  state_e           state_q;
  rk_idx_t          rc_cnt_q;
  rk_idx_t          wr_level_q;
  logic [KEY_W-1:0] cur_key_q;
  logic [KEY_W-1:0] rk_mem [NUM_ROUNDS+1];

  logic             key_ready_q;
  logic             busy_q;
  logic             keys_ready_q;
  logic             done_q;
  logic [KEY_W-1:0] rk_data_q;
  logic             rk_hit_q;

  logic             zero_c;
  logic             load_c;
  logic             step_c;
  logic             last_c;
  logic             wr_en_c;
  rk_idx_t          wr_idx_c;
  logic [KEY_W-1:0] wr_data_c;
  logic [KEY_W-1:0] k_step_c;
  logic             rd_ok_c;

`ifdef KEYSCHED_ZEROIZE_EN
  assign zero_c = zeroize;
`else
  assign zero_c = 1'b0;
`endif

  aes_key_sched_ctrl_key u_key (
    .rc    (rc_cnt_q),
    .k_in  (cur_key_q),
    .k_out (k_step_c)
  );

  // Write-port selection: the initial load writes slot 0, each expand step writes slot rc+1
  always_comb begin
    load_c    = bus.key_valid & key_ready_q & ~zero_c;
    step_c    = (state_q == ST_EXPAND);
    last_c    = step_c && (rc_cnt_q == rk_idx_t'(NUM_ROUNDS - 1));
    wr_en_c   = load_c | step_c;
    wr_idx_c  = load_c ? rk_idx_t'(0) : rk_idx_t'(rc_cnt_q + rk_idx_t'(1));
    wr_data_c = load_c ? bus.key_in : k_step_c;
    rd_ok_c   = (bus.rk_idx <= rk_idx_t'(NUM_ROUNDS));
  end

  // Round-key store and running key
`ifdef KEYSCHED_ZEROIZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_key_q <= '0;
      for (int unsigned i = 0; i < NUM_ROUNDS + 1; i++) rk_mem[i] <= '0;
    end else if (zero_c) begin
      cur_key_q <= '0;
      for (int unsigned i = 0; i < NUM_ROUNDS + 1; i++) rk_mem[i] <= '0;
    end else if (wr_en_c) begin
      rk_mem[wr_idx_c] <= wr_data_c;
      cur_key_q        <= wr_data_c;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      rk_mem[wr_idx_c] <= wr_data_c;
      cur_key_q        <= wr_data_c;
    end
  end
`endif

  // Sequencer FSM with registered status and read-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rc_cnt_q     <= '0;
      wr_level_q   <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      done_q       <= 1'b0;
      rk_data_q    <= '0;
      rk_hit_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      // wr_level before this edge: a same-edge write still reads as a miss with old data
      rk_hit_q  <= rd_ok_c && (bus.rk_idx < wr_level_q);
      rk_data_q <= rd_ok_c ? rk_mem[bus.rk_idx] : '0;
      if (zero_c) begin
        state_q      <= ST_IDLE;
        rc_cnt_q     <= '0;
        wr_level_q   <= '0;
        key_ready_q  <= 1'b1;
        busy_q       <= 1'b0;
        keys_ready_q <= 1'b0;
        rk_data_q    <= '0;
        rk_hit_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (load_c) begin
              state_q      <= ST_LOAD;
              rc_cnt_q     <= '0;
              wr_level_q   <= rk_idx_t'(1);
              key_ready_q  <= 1'b0;
              busy_q       <= 1'b1;
              keys_ready_q <= 1'b0;
            end
          end
          ST_LOAD: begin
            state_q <= ST_EXPAND;
          end
          ST_EXPAND: begin
            wr_level_q <= rk_idx_t'(rc_cnt_q + rk_idx_t'(2));
            if (last_c) begin
              state_q      <= ST_DONE;
              rc_cnt_q     <= '0;
              key_ready_q  <= 1'b1;
              busy_q       <= 1'b0;
              keys_ready_q <= 1'b1;
              done_q       <= 1'b1;
            end else begin
              rc_cnt_q <= rk_idx_t'(rc_cnt_q + rk_idx_t'(1));
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.busy       = busy_q;
  assign bus.keys_ready = keys_ready_q;
  assign bus.done       = done_q;
  assign bus.rk_data    = rk_data_q;
  assign bus.rk_hit     = rk_hit_q;

endmodule
